pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Decides each cycle whether PC and the IF/ID register advance, hold or flush, and whether ID/EX takes a bubble.
- Sources: load-use hazards, taken branches/jumps from the branch unit, and data-memory busy.
- Drives the IF/ID `locker` (load enable) and `resetIn` (flush/load) inputs, the PC enable and the ID/EX bubble; keeps a stall-cycle performance counter.

Parameters:
- BR_PENALTY, 1: extra flush cycles after the redirect cycle (0..3).
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- idRs1  input  5  rs1 field of the instruction in ID.
- idRs2  input  5  rs2 field of the instruction in ID.
- idUseRs1  input  1  ID instruction reads rs1.
- idUseRs2  input  1  ID instruction reads rs2.
- exRd  input  5  rd of the instruction in EX.
- exMemRead  input  1  EX instruction is a load.
- branchTaken  input  1  branch unit redirect request; held by the source until serviced.
- memBusy  input  1  data memory not ready; the whole pipe must freeze.
- pcEn  output  1  PC register load enable.
- ifIdLock  output  1  IF/ID load enable (drives IF/ID `locker`).
- ifIdFlush  output  1  IF/ID flush/load (drives IF/ID `resetIn`).
- idExBubble  output  1  ID/EX inserts a NOP.
- idExEn  output  1  ID/EX load enable.
- stallCnt  output  CNT_W  cycles in which pcEn was 0, excluding reset.

Behaviour:
- States: RUN, FLUSH, MWAIT. State register and counters reset asynchronously when reset=0.
- Values while reset=0: state=RUN, flushCnt=0, stallCnt=0, pcEn=0, ifIdLock=0, ifIdFlush=1, idExBubble=1, idExEn=1.
- Outputs are combinational from state plus the current inputs (zero-latency response). State and counters update on the rising clk edge.
- Load-use hazard: loadUse = exMemRead && exRd!=0 && ((idUseRs1 && exRd==idRs1) || (idUseRs2 && exRd==idRs2)).
- Priority within a cycle, highest first: memBusy, branchTaken, loadUse, normal.
- RUN, normal: pcEn=1, ifIdLock=1, ifIdFlush=0, idExBubble=0, idExEn=1.
- RUN, memBusy=1:
  - pcEn=0, ifIdLock=0, ifIdFlush=0, idExEn=0, idExBubble=0.
  - Next state MWAIT.
  - branchTaken and loadUse are ignored this cycle; the branch unit keeps branchTaken asserted.
- RUN, branchTaken=1:
  - pcEn=1 (loads the target), ifIdLock=1, ifIdFlush=1, idExBubble=1, idExEn=1.
  - If BR_PENALTY>0: next state FLUSH with flushCnt=BR_PENALTY-1. Otherwise stay in RUN.
- RUN, loadUse=1: pcEn=0, ifIdLock=0, ifIdFlush=0, idExBubble=1, idExEn=1. Stay in RUN; the hazard clears after one bubble.
- FLUSH:
  - Outputs as the branchTaken case, except pcEn=1 advances sequentially.
  - When flushCnt==0, next state RUN; otherwise decrement flushCnt.
  - memBusy in FLUSH: outputs as MWAIT; state and flushCnt hold.
  - A new branchTaken in FLUSH reloads flushCnt=BR_PENALTY-1.
- MWAIT:
  - Outputs as the memBusy freeze while memBusy=1.
  - When memBusy=0, return to the state saved on entry (RUN or FLUSH), evaluating that state's rules in the same cycle.
- stallCnt: increments when pcEn=0 and reset=1; wraps modulo 2^CNT_W.
- Writes to x0: exRd==0 never raises loadUse.
- Reset asserted mid-FLUSH or mid-MWAIT: immediate return to the reset values above, no residual flush cycles.

Decomposition:
- define.v: add `StateSize, the state encodings (`S_RUN, `S_FLUSH, `S_MWAIT) and `RegAddrSize (4:0), alongside the existing `DataSize.
- One sub-module: hazard_cmp. It is purely combinational and produces loadUse from idRs1/idRs2/idUse*/exRd/exMemRead.

Test Plan:
- Reset release, all inputs 0 → first cycle pcEn=1, ifIdLock=1, ifIdFlush=0, stallCnt=0; after 10 cycles stallCnt still 0.
- exMemRead=1, exRd=5, idRs2=5, idUseRs2=1 for one cycle → pcEn=0, ifIdLock=0, idExBubble=1 for exactly 1 cycle; stallCnt=1.
- Same as above but exRd=0 → no stall, stallCnt=0.
- branchTaken pulse with BR_PENALTY=1 → ifIdFlush=1 and idExBubble=1 for 2 consecutive cycles, pcEn=1 throughout, then back to RUN.
- memBusy=1 for 3 cycles with branchTaken held high → freeze for 3 cycles (stallCnt=3); on the 4th cycle redirect with ifIdFlush=1.
- reset=0 asserted asynchronously mid-FLUSH → outputs take reset values before the next clk edge; after release state=RUN and stallCnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned FLUSH_CNT_W = 2;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_MWAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_lock;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_en;
  } ctrl_t;

  // Canonical control words, one per pipeline action.
  localparam ctrl_t CTRL_RESET  = '{pc_en: 1'b0, if_id_lock: 1'b0, if_id_flush: 1'b1,
                                    id_ex_bubble: 1'b1, id_ex_en: 1'b1};
  localparam ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, if_id_lock: 1'b1, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, id_ex_en: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_lock: 1'b0, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, id_ex_en: 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{pc_en: 1'b1, if_id_lock: 1'b1, if_id_flush: 1'b1,
                                    id_ex_bubble: 1'b1, id_ex_en: 1'b1};
  localparam ctrl_t CTRL_STALL  = '{pc_en: 1'b0, if_id_lock: 1'b0, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b1, id_ex_en: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use hazard detect: EX load whose rd feeds a source register of the ID instruction.
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use_c
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit    = id_use_rs1 && (ex_rd == id_rs1);
    rs2_hit    = id_use_rs2 && (ex_rd == id_rs2);
    // x0 is never written, so a load targeting it creates no dependency.
    load_use_c = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX enables, flushes and bubbles,
// plus a count of cycles in which the PC did not advance.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  idUseRs1,
  input  logic                  idUseRs2,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exMemRead,
  input  logic                  branchTaken,
  input  logic                  memBusy,
  output logic                  pcEn,
  output logic                  ifIdLock,
  output logic                  ifIdFlush,
  output logic                  idExBubble,
  output logic                  idExEn,
  output logic [CNT_W-1:0]      stallCnt
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT =
    FLUSH_CNT_W'((BR_PENALTY > 0) ? (BR_PENALTY - 1) : 0);

  state_e                 state;
  state_e                 state_nxt;
  state_e                 ret_state;
  state_e                 ret_nxt;
  state_e                 eff_state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [FLUSH_CNT_W-1:0] flush_nxt;
  logic [CNT_W-1:0]       stall_cnt;
  logic                   load_use;
  ctrl_t                  ctrl;

  hazard_cmp u_hazard_cmp (
    .id_rs1      (idRs1),
    .id_rs2      (idRs2),
    .id_use_rs1  (idUseRs1),
    .id_use_rs2  (idUseRs2),
    .ex_rd       (exRd),
    .ex_mem_read (exMemRead),
    .load_use_c  (load_use)
  );

  // State, saved return state and flush/stall counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RUN;
      ret_state <= S_RUN;
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      flush_cnt <= flush_nxt;
      if (!ctrl.pc_en) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // Next state and zero-latency control word; priority memBusy > branch > flush > load-use.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    flush_nxt = flush_cnt;
    ctrl      = CTRL_NORMAL;
    // While frozen in MWAIT the rules of the interrupted state apply once memory is ready.
    eff_state = (state == S_MWAIT) ? ret_state : state;

    if (memBusy) begin
      ctrl = CTRL_FREEZE;
      if (eff_state == S_RUN) begin
        state_nxt = S_MWAIT;
        ret_nxt   = eff_state;
      end
    end else begin
      state_nxt = eff_state;
      if (branchTaken) begin
        ctrl = CTRL_FLUSH;
        if (BR_PENALTY > 0) begin
          state_nxt = S_FLUSH;
          flush_nxt = FLUSH_INIT;
        end else begin
          state_nxt = S_RUN;
        end
      end else if (eff_state == S_FLUSH) begin
        ctrl = CTRL_FLUSH;
        if (flush_cnt == '0) begin
          state_nxt = S_RUN;
        end else begin
          flush_nxt = flush_cnt - FLUSH_CNT_W'(1);
        end
      end else if (load_use) begin
        ctrl = CTRL_STALL;
      end
    end

    if (!reset) begin
      ctrl = CTRL_RESET;
    end
  end

  always_comb begin
    pcEn       = ctrl.pc_en;
    ifIdLock   = ctrl.if_id_lock;
    ifIdFlush  = ctrl.if_id_flush;
    idExBubble = ctrl.id_ex_bubble;
    idExEn     = ctrl.id_ex_en;
    stallCnt   = stall_cnt;
  end

endmodule
